// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Widths, FSM encoding, port indices and result-flag bit positions.
package alu_arb_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned NPORT  = 2;

    localparam int unsigned PORT_CORE = 0;
    localparam int unsigned PORT_ACC  = 1;

    // resp_flags = {overflow, eq, lt, gt}
    localparam int unsigned FLAG_GT  = 0;
    localparam int unsigned FLAG_LT  = 1;
    localparam int unsigned FLAG_EQ  = 2;
    localparam int unsigned FLAG_OVF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]   op0;
        logic [XLEN-1:0]   op1;
        logic [F3_W-1:0]   func3;
        logic [F7_W-1:0]   func7;
        logic [CTRL_W-1:0] ctrl;
    } alu_req_t;

    function automatic logic [NPORT-1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signal bundle of the ALU arbiter.
// slave = arbiter side, master = requesters plus external ALU.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic [NPORT-1:0]  req_valid;
    logic [NPORT-1:0]  req_ready;
    logic [XLEN-1:0]   req_op0_p0;
    logic [XLEN-1:0]   req_op0_p1;
    logic [XLEN-1:0]   req_op1_p0;
    logic [XLEN-1:0]   req_op1_p1;
    logic [F3_W-1:0]   req_func3_p0;
    logic [F3_W-1:0]   req_func3_p1;
    logic [F7_W-1:0]   req_func7_p0;
    logic [F7_W-1:0]   req_func7_p1;
    logic [CTRL_W-1:0] req_ctrl_p0;
    logic [CTRL_W-1:0] req_ctrl_p1;

    logic [NPORT-1:0]  resp_valid;
    logic [NPORT-1:0]  resp_ready;
    logic [XLEN-1:0]   resp_result;
    logic [FLAG_W-1:0] resp_flags;

    logic [XLEN-1:0]   alu_op0;
    logic [XLEN-1:0]   alu_op1;
    logic [F3_W-1:0]   alu_func3;
    logic [F7_W-1:0]   alu_func7;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]   alu_result;
    logic              alu_overflow;
    logic              alu_eq;
    logic              alu_lt;
    logic              alu_gt;

    modport slave (
        input  req_valid, req_op0_p0, req_op0_p1, req_op1_p0, req_op1_p1,
               req_func3_p0, req_func3_p1, req_func7_p0, req_func7_p1,
               req_ctrl_p0, req_ctrl_p1, resp_ready,
               alu_result, alu_overflow, alu_eq, alu_lt, alu_gt,
        output req_ready, resp_valid, resp_result, resp_flags,
               alu_op0, alu_op1, alu_func3, alu_func7, alu_ctrl
    );

    modport master (
        output req_valid, req_op0_p0, req_op0_p1, req_op1_p0, req_op1_p1,
               req_func3_p0, req_func3_p1, req_func7_p0, req_func7_p1,
               req_ctrl_p0, req_ctrl_p1, resp_ready,
               alu_result, alu_overflow, alu_eq, alu_lt, alu_gt,
        input  req_ready, resp_valid, resp_result, resp_flags,
               alu_op0, alu_op1, alu_func3, alu_func7, alu_ctrl
    );

endinterface

// File: rtl/alu_arb_grant.sv
// Grant selection for the ALU arbiter, with its starvation / last-grant state.
// ALU_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation counter.
module alu_arb_grant
    import alu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPORT-1:0] req_valid_i,
    input  logic             en_i,
    output logic [NPORT-1:0] grant_o
);

    logic take;
    logic win_acc;
    logic last_grant_q;
    logic last_grant_d;

    assign take = en_i && (|req_valid_i);

`ifdef ALU_ARB_RR_EN
    // Contention goes to whichever port did not win last time.
    assign win_acc = req_valid_i[PORT_ACC] && (!req_valid_i[PORT_CORE] || !last_grant_q);
`else
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    assign win_acc = req_valid_i[PORT_ACC] &&
                     (!req_valid_i[PORT_CORE] || (starve_cnt_q >= CNT_W'(STARVE_LIMIT)));

    // Count core wins that leave the accelerator waiting, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (take) begin
            if (win_acc) begin
                starve_cnt_d = '0;
            end else if (req_valid_i[PORT_ACC] && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign last_grant_d = take ? win_acc : last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_o = take ? port_onehot(win_acc) : '0;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between the core (port 0) and accelerator (port 1).
// Build option: define ALU_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    state_e            state_q;
    logic              grant_q;
    alu_req_t          alu_q;
    logic [NPORT-1:0]  resp_valid_q;
    logic [XLEN-1:0]   resp_result_q;
    logic [FLAG_W-1:0] resp_flags_q;
    logic              busy_q;

    alu_req_t          req_p0;
    alu_req_t          req_p1;
    alu_req_t          req_sel;
    logic [NPORT-1:0]  grant_oh;
    logic [FLAG_W-1:0] alu_flags;

    assign req_p0 = '{op0: bus.req_op0_p0, op1: bus.req_op1_p0, func3: bus.req_func3_p0,
                      func7: bus.req_func7_p0, ctrl: bus.req_ctrl_p0};
    assign req_p1 = '{op0: bus.req_op0_p1, op1: bus.req_op1_p1, func3: bus.req_func3_p1,
                      func7: bus.req_func7_p1, ctrl: bus.req_ctrl_p1};

    alu_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (bus.req_valid),
        .en_i        (state_q == IDLE),
        .grant_o     (grant_oh)
    );

    assign req_sel = grant_oh[PORT_ACC] ? req_p1 : req_p0;

    always_comb begin
        alu_flags           = '0;
        alu_flags[FLAG_OVF] = bus.alu_overflow;
        alu_flags[FLAG_EQ]  = bus.alu_eq;
        alu_flags[FLAG_LT]  = bus.alu_lt;
        alu_flags[FLAG_GT]  = bus.alu_gt;
    end

    // Accept in IDLE, sample the ALU in EXEC, hold the result in RESP until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            alu_q         <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant_oh) begin
                        alu_q   <= req_sel;
                        grant_q <= grant_oh[PORT_ACC];
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    resp_result_q <= bus.alu_result;
                    resp_flags_q  <= alu_flags;
                    resp_valid_q  <= port_onehot(grant_q);
                    state_q       <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready[grant_q]) begin
                        resp_valid_q <= '0;
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    resp_valid_q <= '0;
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = grant_oh;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_flags  = resp_flags_q;
    assign bus.alu_op0     = alu_q.op0;
    assign bus.alu_op1     = alu_q.op1;
    assign bus.alu_func3   = alu_q.func3;
    assign bus.alu_func7   = alu_q.func7;
    assign bus.alu_ctrl    = alu_q.ctrl;
    assign busy            = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural add/sub ALU and a response scoreboard.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    alu_arbiter_if ifc ();

    alu_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // External ALU: ctrl[6] selects subtract, flags compare the operands as signed.
    function automatic logic [67:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [6:0] c);
        logic [63:0] r;
        logic ovf;
        if (c[6]) begin
            r   = a - b;
            ovf = (a[63] != b[63]) && (r[63] != a[63]);
        end else begin
            r   = a + b;
            ovf = (a[63] == b[63]) && (r[63] != a[63]);
        end
        return {ovf, a == b, $signed(a) < $signed(b), $signed(a) > $signed(b), r};
    endfunction

    assign {ifc.alu_overflow, ifc.alu_eq, ifc.alu_lt, ifc.alu_gt, ifc.alu_result} =
        alu_model(ifc.alu_op0, ifc.alu_op1, ifc.alu_ctrl);

    typedef struct {
        int          port;
        logic [63:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] pa[2];
    logic [63:0] pb[2];
    logic [6:0]  pc[2];

    task automatic set_req(input int p, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] c);
        pa[p] = a;
        pb[p] = b;
        pc[p] = c;
        if (p == 0) begin
            ifc.req_op0_p0   = a;
            ifc.req_op1_p0   = b;
            ifc.req_func3_p0 = f3;
            ifc.req_func7_p0 = f7;
            ifc.req_ctrl_p0  = c;
            ifc.req_valid[0] = 1'b1;
        end else begin
            ifc.req_op0_p1   = a;
            ifc.req_op1_p1   = b;
            ifc.req_func3_p1 = f3;
            ifc.req_func7_p1 = f7;
            ifc.req_ctrl_p1  = c;
            ifc.req_valid[1] = 1'b1;
        end
    endtask

    task automatic push_exp(input int p);
        logic [67:0] m;
        m = alu_model(pa[p], pb[p], pc[p]);
        sb.push_back('{p, m[63:0], m[67:64]});
    endtask

    task automatic wait_ready(output int port, output bit ok);
        ok   = 1'b0;
        port = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.req_ready != 2'b00) begin
                port = ifc.req_ready[1] ? 1 : 0;
                ok   = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_resp(output int port, output bit ok);
        ok   = 1'b0;
        port = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.resp_valid != 2'b00) begin
                port = ifc.resp_valid[1] ? 1 : 0;
                ok   = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ifc.req_valid  = 2'b00;
        ifc.resp_ready = 2'b11;
        set_req(0, 64'd0, 64'd0, 3'd0, 7'd0, 7'd0);
        set_req(1, 64'd0, 64'd0, 3'd0, 7'd0, 7'd0);
        ifc.req_valid = 2'b00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (ifc.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", ifc.req_ready); end
        total++;
        if (ifc.resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid: got %b want 00", ifc.resp_valid); end
        total++;
        if (ifc.resp_result !== 64'd0 || ifc.resp_flags !== 4'd0) begin
            bad++; $display("FAIL reset_resp_data: got %h/%b want 0/0000", ifc.resp_result, ifc.resp_flags);
        end
        total++;
        if ({ifc.alu_op0, ifc.alu_op1, ifc.alu_func3, ifc.alu_func7, ifc.alu_ctrl} !== '0) begin
            bad++; $display("FAIL reset_alu_regs: got op0=%h op1=%h f3=%h f7=%h ctrl=%h want all 0",
                            ifc.alu_op0, ifc.alu_op1, ifc.alu_func3, ifc.alu_func7, ifc.alu_ctrl);
        end
    endtask

    task automatic test_single_op();
        exp_t e;
        @(posedge clk); #1;
        set_req(0, 64'd5, 64'd3, 3'b000, 7'b0100000, 7'b1000000);
        @(negedge clk);
        total++;
        if (ifc.req_ready !== 2'b01) begin bad++; $display("FAIL single_accept: got %b want 01", ifc.req_ready); end
        push_exp(0);
        @(posedge clk); #1 ifc.req_valid = 2'b00;
        @(negedge clk);
        total++;
        if (ifc.resp_valid !== 2'b00 || busy !== 1'b1) begin
            bad++; $display("FAIL single_cycle1: got resp_valid=%b busy=%b want 00/1", ifc.resp_valid, busy);
        end
        total++;
        if (ifc.alu_op0 !== 64'd5 || ifc.alu_op1 !== 64'd3 || ifc.alu_func3 !== 3'b000 ||
            ifc.alu_func7 !== 7'b0100000 || ifc.alu_ctrl !== 7'b1000000) begin
            bad++; $display("FAIL single_alu_regs: got op0=%h op1=%h f3=%b f7=%b ctrl=%b want 5/3/000/0100000/1000000",
                            ifc.alu_op0, ifc.alu_op1, ifc.alu_func3, ifc.alu_func7, ifc.alu_ctrl);
        end
        @(negedge clk);
        total++;
        if (ifc.resp_valid !== 2'b01) begin bad++; $display("FAIL single_latency: got resp_valid=%b want 01", ifc.resp_valid); end
        total++;
        if (ifc.resp_result !== 64'd2 || ifc.resp_flags !== 4'b0001) begin
            bad++; $display("FAIL single_result: got %h/%b want 2/0001", ifc.resp_result, ifc.resp_flags);
        end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL single_sb: got response with empty scoreboard want an entry");
        end else begin
            e = sb.pop_front();
            if (ifc.resp_valid !== port_onehot(e.port[0]) || ifc.resp_result !== e.res || ifc.resp_flags !== e.flg) begin
                bad++; $display("FAIL single_sb: got v=%b %h/%b want port %0d %h/%b",
                                ifc.resp_valid, ifc.resp_result, ifc.resp_flags, e.port, e.res, e.flg);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ifc.resp_valid !== 2'b00) begin
            bad++; $display("FAIL single_release: got busy=%b resp_valid=%b want 0/00", busy, ifc.resp_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int p;
        bit ok;
        logic [63:0] held;
        held = '0;
        @(posedge clk); #1;
        ifc.resp_ready = 2'b00;
        set_req(1, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 3'b010, 7'd0, 7'd0);
        wait_ready(p, ok);
        total++;
        if (!ok || p != 1) begin bad++; $display("FAIL bp_accept_p1: got ok=%0d port=%0d want 1/1", ok, p); end
        push_exp(1);
        @(posedge clk); #1;
        ifc.req_valid = 2'b00;
        set_req(0, 64'd100, 64'd7, 3'b000, 7'd0, 7'b1000000);
        wait_resp(p, ok);
        total++;
        if (!ok || p != 1 || sb.size() == 0) begin
            bad++; $display("FAIL bp_resp_p1: got ok=%0d port=%0d sb=%0d want 1/1/1", ok, p, sb.size());
        end else begin
            e = sb.pop_front();
            held = e.res;
            if (ifc.resp_result !== e.res || ifc.resp_flags !== e.flg) begin
                bad++; $display("FAIL bp_resp_p1_data: got %h/%b want %h/%b", ifc.resp_result, ifc.resp_flags, e.res, e.flg);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ifc.resp_valid !== 2'b10 || ifc.resp_result !== held || ifc.req_ready !== 2'b00) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b want 10/%h/00",
                                i, ifc.resp_valid, ifc.resp_result, ifc.req_ready, held);
            end
        end
        @(posedge clk); #1 ifc.resp_ready = 2'b10;
        @(negedge clk);
        total++;
        if (ifc.resp_valid !== 2'b10 || ifc.req_ready !== 2'b00) begin
            bad++; $display("FAIL bp_before_hs: got v=%b rdy=%b want 10/00", ifc.resp_valid, ifc.req_ready);
        end
        @(posedge clk); #1 ifc.resp_ready = 2'b11;
        @(negedge clk);
        total++;
        if (ifc.resp_valid !== 2'b00 || ifc.req_ready !== 2'b01) begin
            bad++; $display("FAIL bp_after_hs: got v=%b rdy=%b want 00/01", ifc.resp_valid, ifc.req_ready);
        end
        push_exp(0);
        @(posedge clk); #1 ifc.req_valid = 2'b00;
        wait_resp(p, ok);
        total++;
        if (!ok || p != 0 || sb.size() == 0) begin
            bad++; $display("FAIL bp_resp_p0: got ok=%0d port=%0d sb=%0d want 1/0/1", ok, p, sb.size());
        end else begin
            e = sb.pop_front();
            if (ifc.resp_result !== e.res || ifc.resp_flags !== e.flg) begin
                bad++; $display("FAIL bp_resp_p0_data: got %h/%b want %h/%b", ifc.resp_result, ifc.resp_flags, e.res, e.flg);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        exp_t e;
        int p;
        int rp;
        bit ok;
        int exp_seq[10];
`ifdef ALU_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        ifc.resp_ready = 2'b11;
        set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 3'b000, 7'd0, 7'b1000000);
        set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 3'b111, 7'd0, 7'd0);
        for (int i = 0; i < 10; i++) begin
            wait_ready(p, ok);
            total++;
            if (!ok || p != exp_seq[i]) begin
                bad++; $display("FAIL contention_grant%0d: got ok=%0d port=%0d want port %0d", i, ok, p, exp_seq[i]);
            end
            if (!ok) break;
            push_exp(p);
            @(posedge clk); #1;
            set_req(p, {$urandom, $urandom}, {$urandom, $urandom}, 3'b000, 7'd0, 7'($urandom_range(0, 1) << 6));
            wait_resp(rp, ok);
            total++;
            if (!ok || sb.size() == 0) begin
                bad++; $display("FAIL contention_resp%0d: got ok=%0d sb=%0d want 1/1", i, ok, sb.size());
                break;
            end else begin
                e = sb.pop_front();
                if (rp != e.port || ifc.resp_result !== e.res || ifc.resp_flags !== e.flg) begin
                    bad++; $display("FAIL contention_resp%0d: got port %0d %h/%b want port %0d %h/%b",
                                    i, rp, ifc.resp_result, ifc.resp_flags, e.port, e.res, e.flg);
                end
            end
        end
        ifc.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        ifc.resp_ready = 2'b11;
        set_req(0, 64'hdead_beef_0000_0001, 64'h0000_0000_0000_0002, 3'b110, 7'h3f, 7'h41);
        @(negedge clk);
        total++;
        if (ifc.req_ready !== 2'b01) begin bad++; $display("FAIL midrst_accept: got %b want 01", ifc.req_ready); end
        @(posedge clk); #1;
        ifc.req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ifc.resp_valid !== 2'b00) begin
            bad++; $display("FAIL midrst_state: got busy=%b resp_valid=%b want 0/00", busy, ifc.resp_valid);
        end
        total++;
        if ({ifc.alu_op0, ifc.alu_op1, ifc.alu_func3, ifc.alu_func7, ifc.alu_ctrl} !== '0) begin
            bad++; $display("FAIL midrst_alu_regs: got op0=%h op1=%h ctrl=%h want 0", ifc.alu_op0, ifc.alu_op1, ifc.alu_ctrl);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (ifc.resp_valid !== 2'b00) begin
                bad++; $display("FAIL midrst_no_resp%0d: got resp_valid=%b want 00", i, ifc.resp_valid);
            end
        end
    endtask

    task automatic test_idle_stable();
        exp_t e;
        int p;
        bit ok;
        @(posedge clk); #1;
        ifc.resp_ready = 2'b11;
        set_req(1, 64'h7777_0000_1111_2222, 64'h0000_3333_4444_5555, 3'b101, 7'h11, 7'h05);
        wait_ready(p, ok);
        total++;
        if (!ok || p != 1) begin bad++; $display("FAIL idle_accept: got ok=%0d port=%0d want 1/1", ok, p); end
        push_exp(1);
        @(posedge clk); #1 ifc.req_valid = 2'b00;
        wait_resp(p, ok);
        total++;
        if (!ok || p != 1 || sb.size() == 0) begin
            bad++; $display("FAIL idle_resp: got ok=%0d port=%0d sb=%0d want 1/1/1", ok, p, sb.size());
        end else begin
            e = sb.pop_front();
            if (ifc.resp_result !== e.res || ifc.resp_flags !== e.flg) begin
                bad++; $display("FAIL idle_resp_data: got %h/%b want %h/%b", ifc.resp_result, ifc.resp_flags, e.res, e.flg);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || ifc.req_ready !== 2'b00 || ifc.alu_op0 !== 64'h7777_0000_1111_2222 ||
                ifc.alu_op1 !== 64'h0000_3333_4444_5555 || ifc.alu_func3 !== 3'b101 ||
                ifc.alu_func7 !== 7'h11 || ifc.alu_ctrl !== 7'h05) begin
                bad++; $display("FAIL idle_hold%0d: got busy=%b rdy=%b op0=%h op1=%h f3=%b f7=%h ctrl=%h",
                                i, busy, ifc.req_ready, ifc.alu_op0, ifc.alu_op1, ifc.alu_func3, ifc.alu_func7, ifc.alu_ctrl);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want earlier finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_contention();
        test_mid_reset();
        test_idle_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 64-bit ALU between two requesters: port 0 is the core's execute stage, port 1 is the hardware accelerator.
- Arbitrates, latches the winner's operands into registers that drive the ALU, captures the ALU outputs one cycle later, and returns them on the winner's response channel.
- Sits between the requesters and one ALU instance. The ALU stays combinational and external.

Parameters:
- STARVE_LIMIT, 4: consecutive port-0 grants while port 1 waits, after which port 1 is forced.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  per-port request valid; bit i is port i.
- req_ready  out  2  per-port accept, one-hot or zero.
- req_op0_p0 / req_op0_p1  in  64  operand 0 per port.
- req_op1_p0 / req_op1_p1  in  64  operand 1 per port.
- req_func3_p0 / req_func3_p1  in  3  func3 per port.
- req_func7_p0 / req_func7_p1  in  7  func7 per port.
- req_ctrl_p0 / req_ctrl_p1  in  7  decode ctrl per port.
- resp_valid  out  2  per-port result valid.
- resp_ready  in  2  per-port result accept.
- resp_result  out  64  shared result bus; meaningful only where resp_valid is set.
- resp_flags  out  4  {overflow, eq, lt, gt}.
- alu_op0, alu_op1  out  64  registered operands to the ALU.
- alu_func3  out  3  registered func3 to the ALU.
- alu_func7  out  7  registered func7 to the ALU.
- alu_ctrl  out  7  registered ctrl to the ALU.
- alu_result  in  64  ALU result.
- alu_overflow, alu_eq, alu_lt, alu_gt  in  1 each  ALU flags.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset is synchronous and active-high; all state is cleared on the clk edge where reset is high. This is fixed.
- Reset values:
  - state = IDLE.
  - req_ready = 0, resp_valid = 0, resp_result = 0, resp_flags = 0.
  - All alu_* registers = 0.
  - busy = 0, starve_cnt = 0, grant = 0, last_grant = 1.
- States:
  - IDLE -> EXEC: taken when any req_valid bit is set.
    - A grant is computed combinationally.
    - req_ready[grant] = 1 in that same cycle; the handshake completes that cycle.
    - The granted port's fields are registered into alu_*, and grant is stored.
  - EXEC: lasts exactly one cycle. alu_result and the flags are registered into resp_result and resp_flags. Next state is RESP.
  - RESP: resp_valid[grant] = 1.
    - It holds, with stable data, until resp_ready[grant] = 1 on a clock edge.
    - Then resp_valid clears and the next state is IDLE.
- Timing: minimum latency from accept to resp_valid is 2 cycles. Maximum throughput is one operation per 3 cycles.
- req_ready is 0 outside IDLE. Requesters hold valid and fields stable until ready.
- Arbitration (default, fixed priority):
  - Port 0 wins unless req_valid[1] = 1 and starve_cnt >= STARVE_LIMIT; then port 1 wins.
  - starve_cnt increments on each port-0 grant while req_valid[1] = 1.
  - starve_cnt clears on any port-1 grant.
  - starve_cnt saturates at STARVE_LIMIT.
- Single requester: that port always wins, whatever the policy.
- resp_valid is never asserted for both ports. The non-granted bit is always 0.
- A requester dropping req_valid while not ready is legal; nothing is recorded.
- Reset in EXEC or RESP: the in-flight operation is discarded, no response is produced, and the requester must reissue.
- alu_* outputs hold their last value in IDLE; they do not toggle.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both ports are valid, the port that is not last_grant wins.
  - last_grant updates on every grant.
  - starve_cnt and STARVE_LIMIT are unused and tie to 0.
- Undefined: fixed priority with starvation counter, as above. last_grant is still maintained but does not affect grants.

Decomposition:
- Shared package alu_arb_pkg holds:
  - state encoding constants: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
  - port index constants: PORT_CORE = 0, PORT_ACC = 1.
  - flag bit positions within resp_flags.
- Natural sub-module: alu_arb_grant, the combinational grant logic plus the starve_cnt / last_grant register.
  - Inputs: req_valid, and an enable that is high in IDLE.
  - Output: one-hot grant.

Test Plan:
- Single op on port 0:
  - Stimulus: op0 = 5, op1 = 3, func3 = 000, func7 = 0100000, ctrl[6] = 1; external ALU returns 2.
  - Response: req_ready[0] in cycle 0; resp_valid[0] in cycle 2 with result 2, flags lt = 0 and gt = 1.
- Response backpressure:
  - Stimulus: port 1 issues one op; resp_ready[1] held 0 for 5 cycles.
  - Response: resp_valid[1] and resp_result stay stable; req_ready stays 0 on a new port-0 request; port 0 is accepted the cycle after the resp handshake.
- Contention, fixed priority, STARVE_LIMIT = 4:
  - Stimulus: both ports continuously valid.
  - Response: grant sequence 0,0,0,0,1,0,0,0,0,1.
- Contention with ALU_ARB_RR_EN defined:
  - Stimulus: both ports continuously valid from reset.
  - Response: grant sequence 0,1,0,1.
- Mid-operation reset:
  - Stimulus: assert reset in EXEC.
  - Response: next cycle state = IDLE; resp_valid = 0; all alu_* = 0; no response ever issued for that op.
- Idle stability:
  - Stimulus: no requests for 10 cycles after one completed op.
  - Response: busy = 0; alu_* unchanged; req_ready = 0.
